// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int BE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - data-first priority select with starvation override for fetch
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_hit,
    output logic grant_i,
    output logic grant_d
);

    // starve_hit only matters when both ports are asking
    assign grant_i = i_req & (~d_req | starve_hit);
    assign grant_d = d_req & ~(i_req & starve_hit);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of one single-port SRAM
// Optional fetch starvation guard enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [BE_W-1:0]   d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    owner_t              r_owner;
    logic                r_is_write;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-3:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_pick_i;
    logic w_pick_d;
    logic w_arb_ok;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_starve_hit;
    logic w_resp;
    logic w_unused_addr_bits;

    assign w_unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_hit (w_starve_hit),
        .grant_i    (w_pick_i),
        .grant_d    (w_pick_d)
    );

    // Grants are gated by rst_n so every output reads 0 while reset is held
    assign w_arb_ok = rst_n & (r_state != ISSUE);
    assign w_gnt_i  = w_arb_ok & w_pick_i;
    assign w_gnt_d  = w_arb_ok & w_pick_d;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_i || !i_req) begin
            r_starve_cnt <= '0;
        end else if (w_gnt_d && (r_starve_cnt != LIMIT_V)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_starve_hit = (r_starve_cnt == LIMIT_V);
`else
    assign w_starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_is_write  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= w_gnt_i | w_gnt_d;
            if (w_gnt_d) begin
                r_owner     <= OWN_D;
                r_is_write  <= d_we;
                r_mem_we    <= d_we;
                r_mem_be    <= d_we ? d_be : '1;
                r_mem_addr  <= d_addr[ADDR_W-1:2];
                r_mem_wdata <= d_we ? d_wdata : '0;
            end else if (w_gnt_i) begin
                r_owner     <= OWN_I;
                r_is_write  <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= i_addr[ADDR_W-1:2];
                r_mem_wdata <= '0;
            end else begin
                r_mem_we    <= 1'b0;
            end

            case (r_state)
                IDLE:    r_state <= (w_gnt_i | w_gnt_d) ? ISSUE : IDLE;
                ISSUE:   r_state <= RESP;
                RESP:    r_state <= (w_gnt_i | w_gnt_d) ? ISSUE : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_gnt     = w_gnt_i;
    assign d_gnt     = w_gnt_d;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // SRAM data arrives the cycle after the strobe, so it is steered straight through
    assign w_resp   = (r_state == RESP);
    assign i_rvalid = w_resp & (r_owner == OWN_I);
    assign d_rvalid = w_resp & (r_owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = (d_rvalid & ~r_is_write) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with an SRAM model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] sram [0:63];

    int checks = 0;
    int failures = 0;
    int adj_en_errs = 0;
    logic prev_en = 1'b0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[5:0]];
            end
        end
    end

    always @(negedge clk) begin
        if (prev_en && mem_en) adj_en_errs++;
        prev_en = mem_en;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] gnt_d_mask;
    logic [9:0] gnt_i_mask;
    logic [9:0] exp_d_mask;
    logic [9:0] exp_i_mask;

    initial begin
        for (int k = 0; k < 64; k++) sram[k] = 32'h1000_0000 + k;
        sram[4]  = 32'hDEAD_BEEF;
        sram[5]  = 32'h5555_AAAA;
        sram[8]  = 32'hAABB_CCDD;
        sram[16] = 32'hA5A5_0016;

        // outputs held at 0 while in reset, even with requests present
        i_req = 1'b1;
        d_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {62'b0, i_gnt, d_gnt}, 64'd0);
        check("rst_mem_en", {63'b0, mem_en}, 64'd0);
        check("rst_rvalid", {62'b0, i_rvalid, d_rvalid}, 64'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // single fetch
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("sf_i_gnt", {63'b0, i_gnt}, 64'd1);
        check("sf_d_gnt", {63'b0, d_gnt}, 64'd0);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check("sf_mem_en", {63'b0, mem_en}, 64'd1);
        check("sf_mem_addr", {34'b0, mem_addr}, 64'd4);
        check("sf_mem_we", {63'b0, mem_we}, 64'd0);
        check("sf_mem_be", {60'b0, mem_be}, 64'hF);
        next_cycle();
        @(negedge clk);
        check("sf_i_rvalid", {63'b0, i_rvalid}, 64'd1);
        check("sf_i_rdata", {32'b0, i_rdata}, 64'hDEAD_BEEF);
        check("sf_d_rvalid", {63'b0, d_rvalid}, 64'd0);
        next_cycle();

        // contention: data first, fetch two cycles later
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(negedge clk);
        check("ct_d_gnt0", {63'b0, d_gnt}, 64'd1);
        check("ct_i_gnt0", {63'b0, i_gnt}, 64'd0);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("ct_mem_addr1", {34'b0, mem_addr}, 64'd16);
        check("ct_i_gnt1", {63'b0, i_gnt}, 64'd0);
        next_cycle();
        @(negedge clk);
        check("ct_d_rvalid2", {63'b0, d_rvalid}, 64'd1);
        check("ct_d_rdata2", {32'b0, d_rdata}, 64'hA5A5_0016);
        check("ct_i_gnt2", {63'b0, i_gnt}, 64'd1);
        check("ct_i_rvalid2", {63'b0, i_rvalid}, 64'd0);
        next_cycle();
        i_req = 1'b0;
        @(negedge clk);
        check("ct_mem_addr3", {34'b0, mem_addr}, 64'd5);
        next_cycle();
        @(negedge clk);
        check("ct_i_rvalid4", {63'b0, i_rvalid}, 64'd1);
        check("ct_i_rdata4", {32'b0, i_rdata}, 64'h5555_AAAA);
        check("ct_d_rvalid4", {63'b0, d_rvalid}, 64'd0);
        next_cycle();

        // partial byte write then read back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_be = 4'b0011;
        @(negedge clk);
        check("bw_d_gnt", {63'b0, d_gnt}, 64'd1);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; d_be = 4'b0000;
        @(negedge clk);
        check("bw_mem_we", {63'b0, mem_we}, 64'd1);
        check("bw_mem_addr", {34'b0, mem_addr}, 64'd8);
        check("bw_mem_be", {60'b0, mem_be}, 64'h3);
        check("bw_mem_wdata", {32'b0, mem_wdata}, 64'h1234_5678);
        next_cycle();
        @(negedge clk);
        check("bw_d_rvalid", {63'b0, d_rvalid}, 64'd1);
        check("bw_d_rdata", {32'b0, d_rdata}, 64'd0);
        next_cycle();
        d_req = 1'b1; d_addr = 32'h20;
        @(negedge clk);
        check("rb_d_gnt", {63'b0, d_gnt}, 64'd1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        check("rb_mem_be", {60'b0, mem_be}, 64'hF);
        check("rb_mem_we", {63'b0, mem_we}, 64'd0);
        next_cycle();
        @(negedge clk);
        check("rb_d_rdata", {32'b0, d_rdata}, 64'hAABB_5678);
        next_cycle();

        // back-to-back fetches 0x0, 0x4, 0x8
        gnt_i_mask = '0;
        for (int c = 0; c < 7; c++) begin
            i_req  = (c < 5);
            i_addr = 32'(c / 2) * 32'd4;
            @(negedge clk);
            gnt_i_mask[c] = i_gnt;
            if (c == 2 || c == 4 || c == 6) begin
                check("bb_i_rvalid", {63'b0, i_rvalid}, 64'd1);
                check("bb_i_rdata", {32'b0, i_rdata}, 64'h1000_0000 + 64'(c / 2 - 1));
            end
            next_cycle();
        end
        i_req = 1'b0;
        check("bb_i_gnt_mask", {57'b0, gnt_i_mask[6:0]}, 64'h15);

        // starvation: both held for ten cycles
`ifdef MEM_ARB_FAIR_EN
        exp_d_mask = 10'h055;
        exp_i_mask = 10'h100;
`else
        exp_d_mask = 10'h155;
        exp_i_mask = 10'h000;
`endif
        gnt_d_mask = '0;
        gnt_i_mask = '0;
        for (int c = 0; c < 10; c++) begin
            i_req = 1'b1; i_addr = 32'h0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
            @(negedge clk);
            gnt_d_mask[c] = d_gnt;
            gnt_i_mask[c] = i_gnt;
            next_cycle();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (3) next_cycle();
        check("st_d_gnt_mask", {54'b0, gnt_d_mask}, {54'b0, exp_d_mask});
        check("st_i_gnt_mask", {54'b0, gnt_i_mask}, {54'b0, exp_i_mask});
        check("mem_en_adjacent", 64'(adj_en_errs), 64'd0);

        // reset during ISSUE of a read
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("rm_i_gnt", {63'b0, i_gnt}, 64'd1);
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b1; d_addr = 32'h0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_mem_en", {63'b0, mem_en}, 64'd0);
        check("rm_gnt", {62'b0, i_gnt, d_gnt}, 64'd0);
        check("rm_mem_bus", {30'b0, mem_addr, mem_be}, 64'd0);
        next_cycle();
        d_req = 1'b0;
        #3;
        rst_n = 1'b1;
        gnt_i_mask = '0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            gnt_i_mask[c] = i_rvalid | d_rvalid;
        end
        check("rm_no_rvalid", {54'b0, gnt_i_mask}, 64'd0);
        next_cycle();
        d_req = 1'b1; d_addr = 32'h10;
        @(negedge clk);
        check("rm_idle_gnt", {63'b0, d_gnt}, 64'd1);
        next_cycle();
        d_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("rm_d_rdata", {32'b0, d_rdata}, 64'hDEAD_BEEF);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
